alu_exec_seq: RTL and testbench
===============================

Name: alu_exec_seq

Overview:
- Parametrised, sequential successor to the combinational ALU datapath.
- Accepts one decoded operation with already-read operands (a = Rsrc1 value, b = Rsrc2 value) plus destination register addresses over a valid/ready handshake.
- Executes single-cycle logic/arith ops and iterative W-cycle multiply/divide, then presents registered results, destination addresses and status flags to writeback over a second valid/ready handshake.
- Sits between decode/register read and register-file writeback.

Parameters:
- W, 16, datapath width; must be a power of two, >= 4.
- OPC_W, 6, opcode width.
- RA_W, 5, register address width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operation offered.
- in_ready  out  1  block can accept; high only in IDLE.
- in_opcode  in  OPC_W  operation code.
- in_a  in  W  operand a (Rsrc1).
- in_b  in  W  operand b (Rsrc2).
- in_dst1  in  RA_W  destination for low result (Rdst1).
- in_dst2  in  RA_W  destination for high result or remainder (Rdst2).
- out_valid  out  1  result available.
- out_ready  in  1  writeback accepts result.
- out_lo  out  W  primary result.
- out_hi  out  W  MUL high half or DIV remainder; 0 otherwise.
- out_dst1  out  RA_W  registered in_dst1.
- out_dst2  out  RA_W  registered in_dst2.
- out_wr_hi  out  1  out_hi must be written to out_dst2 (MUL, DIV only).
- out_flags  out  5  {ILL, DZ, V, C, Z}.
- busy  out  1  state != IDLE.

Behaviour:
- Reset: asynchronous, active-low. Clears all outputs and internal state to 0, state = IDLE, in_ready = 1. Takes effect immediately, including mid-MUL/DIV; the in-flight operation is discarded with no output.
- Handshakes: input transfer on a rising edge with in_valid && in_ready. Output transfer on a rising edge with out_valid && out_ready.
- While out_valid = 1, all out_* are held stable until transfer.

FSM states:
- IDLE: on accept, capture opcode, operands and dsts. MUL/DIV go to ITER with counter = 0; all other opcodes go to EXEC.
- EXEC: compute, register results, go to DONE.
- ITER: one radix-2 step per cycle (MUL shift-add, DIV restoring). After W steps, register the result and go to DONE.
- DONE: out_valid = 1. On output transfer go to IDLE.
- in_ready is low in all states except IDLE; there is no back-to-back accept.

Latency (counted from the acceptance edge):
- Single-cycle ops: out_valid high after the 2nd following edge.
- MUL/DIV: out_valid high after W+1 edges.

Opcodes and results (all unsigned unless stated):
- 000100 ADD: lo = b+a.
- 000101 SUB: lo = b-a, computed as b + ~a + 1 (true two's complement).
- 000110 NEG: lo = -a.
- 000111 MUL: {hi,lo} = a*b.
- 001000 DIV: lo = b/a, hi = b%a.
- 001001 OR, 001010 XOR, 001011 NAND, 001100 NOR, 001101 XNOR: bitwise b op a.
- 001110 NOT: lo = ~a.
- 001111 LLSH: lo = b << a[log2W-1:0].
- 010000 LRSH: lo = b >> a[log2W-1:0], logical.
- All other opcodes: lo = hi = 0, ILL = 1, single-cycle path.

Flags:
- Z = (lo == 0) for every legal op.
- C:
  - ADD: carry out.
  - SUB: carry out of b + ~a + 1, i.e. 1 means no borrow.
  - NEG: 1 iff a == 0.
  - Shifts: last bit shifted out; 0 when shift amount is 0.
  - All other ops: 0.
- V:
  - ADD/SUB: signed overflow.
  - NEG: a == 100..0.
  - MUL: hi != 0.
  - All other ops: 0.
- DZ: DIV with a == 0. Result lo = all ones, hi = b; the full W-cycle latency still applies.
- ILL: as defined for unlisted opcodes; in that case Z = C = V = DZ = 0.
- out_wr_hi = 1 only for MUL and DIV, including divide-by-zero.

Simultaneous events and boundaries:
- in_valid is ignored outside IDLE; input fields are don't-care when in_valid = 0.
- out_ready asserted before out_valid has no effect.
- The iteration counter is log2(W)+1 bits wide and never wraps within an operation.

Test Plan:
- ADD b=0xFFFF, a=0x0001 -> lo=0x0000, Z=1, C=1, V=0, out_wr_hi=0; out_valid after the 2nd edge post-accept.
- SUB b=0x8000, a=0x0001 -> lo=0x7FFF, C=1, V=1, Z=0. Then NEG a=0x8000 -> lo=0x8000, V=1.
- MUL a=0x1234, b=0x5678 -> hi=0x0626, lo=0x0060, V=1, out_wr_hi=1; out_valid exactly 17 edges after accept; in_ready low throughout.
- DIV b=100, a=7 -> lo=14, hi=2, DZ=0. Then DIV b=0x00AB, a=0 -> lo=0xFFFF, hi=0x00AB, DZ=1, latency 17.
- LLSH b=0x8001, a=0x0011 (amount 1) -> lo=0x0002, C=1. Then hold out_ready=0 for 5 cycles -> outputs stable, in_ready=0; transfer on out_ready=1, IDLE on the next cycle. Then opcode 111111 -> ILL=1, lo=0.
- Assert rst_n=0 at iteration 8 of a MUL -> all outputs 0 asynchronously, no out_valid. After release, ADD b=3, a=4 -> lo=7.

Source files
------------

// File: rtl/alu_exec_seq_if.sv
// Handshake bundle between decode/register-read, the sequential ALU and writeback.
interface alu_exec_seq_if #(
  parameter int W     = 16,
  parameter int OPC_W = 6,
  parameter int RA_W  = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [OPC_W-1:0] in_opcode;
  logic [W-1:0]     in_a;
  logic [W-1:0]     in_b;
  logic [RA_W-1:0]  in_dst1;
  logic [RA_W-1:0]  in_dst2;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     out_lo;
  logic [W-1:0]     out_hi;
  logic [RA_W-1:0]  out_dst1;
  logic [RA_W-1:0]  out_dst2;
  logic             out_wr_hi;
  logic [4:0]       out_flags;
  logic             busy;

  // Upstream/downstream side driving operations in and taking results out.
  modport master (
    output in_valid, in_opcode, in_a, in_b, in_dst1, in_dst2, out_ready,
    input  in_ready, out_valid, out_lo, out_hi, out_dst1, out_dst2,
           out_wr_hi, out_flags, busy
  );

  // ALU side.
  modport slave (
    input  in_valid, in_opcode, in_a, in_b, in_dst1, in_dst2, out_ready,
    output in_ready, out_valid, out_lo, out_hi, out_dst1, out_dst2,
           out_wr_hi, out_flags, busy
  );
endinterface

// File: rtl/alu_exec_seq.sv
// Sequential ALU: single-cycle logic/arith ops plus W-step shift-add multiply
// and restoring divide. Flags are {ILL, DZ, V, C, Z}. All outputs registered.
module alu_exec_seq #(
  parameter int W     = 16,
  parameter int OPC_W = 6,
  parameter int RA_W  = 5
) (
  input logic          clk,
  input logic          rst_n,
  alu_exec_seq_if.slave bus
);
  localparam int LW = $clog2(W);
  localparam int CW = LW + 1;

  localparam logic [OPC_W-1:0] OP_ADD  = OPC_W'(6'b000100);
  localparam logic [OPC_W-1:0] OP_SUB  = OPC_W'(6'b000101);
  localparam logic [OPC_W-1:0] OP_NEG  = OPC_W'(6'b000110);
  localparam logic [OPC_W-1:0] OP_MUL  = OPC_W'(6'b000111);
  localparam logic [OPC_W-1:0] OP_DIV  = OPC_W'(6'b001000);
  localparam logic [OPC_W-1:0] OP_OR   = OPC_W'(6'b001001);
  localparam logic [OPC_W-1:0] OP_XOR  = OPC_W'(6'b001010);
  localparam logic [OPC_W-1:0] OP_NAND = OPC_W'(6'b001011);
  localparam logic [OPC_W-1:0] OP_NOR  = OPC_W'(6'b001100);
  localparam logic [OPC_W-1:0] OP_XNOR = OPC_W'(6'b001101);
  localparam logic [OPC_W-1:0] OP_NOT  = OPC_W'(6'b001110);
  localparam logic [OPC_W-1:0] OP_LLSH = OPC_W'(6'b001111);
  localparam logic [OPC_W-1:0] OP_LRSH = OPC_W'(6'b010000);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_ITER, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [OPC_W-1:0] op_q, op_d;
  logic [W-1:0]     a_q, a_d, b_q, b_d;
  logic [W-1:0]     acc_hi_q, acc_hi_d, acc_lo_q, acc_lo_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [W-1:0]     out_lo_q, out_lo_d, out_hi_q, out_hi_d;
  logic [RA_W-1:0]  out_dst1_q, out_dst1_d, out_dst2_q, out_dst2_d;
  logic             out_wr_hi_q, out_wr_hi_d;
  logic [4:0]       out_flags_q, out_flags_d;
  logic             out_valid_q, out_valid_d;
  logic             in_ready_q, in_ready_d;
  logic             busy_q, busy_d;

  // Datapath intermediates
  logic [W:0]       add_s, sub_s, shl_s, shr_s, mul_sum_s, div_shift_s;
  logic [W-1:0]     div_rem_s, alu_lo_s, step_hi_s, step_lo_s;
  logic [LW-1:0]    sh_s;
  logic             div_ok_s, alu_c_s, alu_v_s, alu_ill_s, is_mul_s;

  // State and output registers; reset discards any in-flight operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      op_q        <= {OPC_W{1'b0}};
      a_q         <= {W{1'b0}};
      b_q         <= {W{1'b0}};
      acc_hi_q    <= {W{1'b0}};
      acc_lo_q    <= {W{1'b0}};
      cnt_q       <= {CW{1'b0}};
      out_lo_q    <= {W{1'b0}};
      out_hi_q    <= {W{1'b0}};
      out_dst1_q  <= {RA_W{1'b0}};
      out_dst2_q  <= {RA_W{1'b0}};
      out_wr_hi_q <= 1'b0;
      out_flags_q <= 5'b00000;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      acc_hi_q    <= acc_hi_d;
      acc_lo_q    <= acc_lo_d;
      cnt_q       <= cnt_d;
      out_lo_q    <= out_lo_d;
      out_hi_q    <= out_hi_d;
      out_dst1_q  <= out_dst1_d;
      out_dst2_q  <= out_dst2_d;
      out_wr_hi_q <= out_wr_hi_d;
      out_flags_q <= out_flags_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
    end
  end

  // Single-cycle ALU result and flags from the captured operands.
  always_comb begin
    sh_s      = a_q[LW-1:0];
    add_s     = {1'b0, b_q} + {1'b0, a_q};
    sub_s     = {1'b0, b_q} + {1'b0, ~a_q} + {{W{1'b0}}, 1'b1};
    shl_s     = {1'b0, b_q} << sh_s;   // bit W is the last bit shifted out
    shr_s     = {b_q, 1'b0} >> sh_s;   // bit 0 is the last bit shifted out
    alu_lo_s  = {W{1'b0}};
    alu_c_s   = 1'b0;
    alu_v_s   = 1'b0;
    alu_ill_s = 1'b0;
    case (op_q)
      OP_ADD: begin
        alu_lo_s = add_s[W-1:0];
        alu_c_s  = add_s[W];
        alu_v_s  = (a_q[W-1] == b_q[W-1]) && (add_s[W-1] != b_q[W-1]);
      end
      OP_SUB: begin
        alu_lo_s = sub_s[W-1:0];
        alu_c_s  = sub_s[W];
        alu_v_s  = (a_q[W-1] != b_q[W-1]) && (sub_s[W-1] != b_q[W-1]);
      end
      OP_NEG: begin
        alu_lo_s = ~a_q + {{(W-1){1'b0}}, 1'b1};
        alu_c_s  = (a_q == {W{1'b0}});
        alu_v_s  = (a_q == {1'b1, {(W-1){1'b0}}});
      end
      OP_OR:   alu_lo_s = b_q | a_q;
      OP_XOR:  alu_lo_s = b_q ^ a_q;
      OP_NAND: alu_lo_s = ~(b_q & a_q);
      OP_NOR:  alu_lo_s = ~(b_q | a_q);
      OP_XNOR: alu_lo_s = ~(b_q ^ a_q);
      OP_NOT:  alu_lo_s = ~a_q;
      OP_LLSH: begin
        alu_lo_s = shl_s[W-1:0];
        alu_c_s  = shl_s[W];
      end
      OP_LRSH: begin
        alu_lo_s = shr_s[W:1];
        alu_c_s  = shr_s[0];
      end
      default: alu_ill_s = 1'b1;
    endcase
  end

  // One radix-2 step: shift-add multiply or restoring divide on acc_hi:acc_lo.
  always_comb begin
    is_mul_s    = (op_q == OP_MUL);
    mul_sum_s   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, a_q} : {(W+1){1'b0}});
    div_shift_s = {acc_hi_q, acc_lo_q[W-1]};
    div_ok_s    = (div_shift_s >= {1'b0, a_q});
    div_rem_s   = W'(div_shift_s - {1'b0, a_q});
    if (is_mul_s) begin
      step_hi_s = mul_sum_s[W:1];
      step_lo_s = {mul_sum_s[0], acc_lo_q[W-1:1]};
    end else if (div_ok_s) begin
      step_hi_s = div_rem_s;
      step_lo_s = {acc_lo_q[W-2:0], 1'b1};
    end else begin
      step_hi_s = div_shift_s[W-1:0];
      step_lo_s = {acc_lo_q[W-2:0], 1'b0};
    end
  end

  // Next-state and output-register update for the IDLE/EXEC/ITER/DONE sequence.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    acc_hi_d    = acc_hi_q;
    acc_lo_d    = acc_lo_q;
    cnt_d       = cnt_q;
    out_lo_d    = out_lo_q;
    out_hi_d    = out_hi_q;
    out_dst1_d  = out_dst1_q;
    out_dst2_d  = out_dst2_q;
    out_wr_hi_d = out_wr_hi_q;
    out_flags_d = out_flags_q;
    out_valid_d = out_valid_q;
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          op_d       = bus.in_opcode;
          a_d        = bus.in_a;
          b_d        = bus.in_b;
          out_dst1_d = bus.in_dst1;
          out_dst2_d = bus.in_dst2;
          cnt_d      = {CW{1'b0}};
          acc_hi_d   = {W{1'b0}};
          acc_lo_d   = bus.in_b;
          if ((bus.in_opcode == OP_MUL) || (bus.in_opcode == OP_DIV)) begin
            state_d = S_ITER;
          end else begin
            state_d = S_EXEC;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_EXEC: begin
        out_lo_d    = alu_lo_s;
        out_hi_d    = {W{1'b0}};
        out_wr_hi_d = 1'b0;
        out_flags_d = {alu_ill_s, 1'b0, alu_v_s, alu_c_s,
                       (!alu_ill_s) && (alu_lo_s == {W{1'b0}})};
        state_d     = S_DONE;
      end
      S_ITER: begin
        acc_hi_d = step_hi_s;
        acc_lo_d = step_lo_s;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CW'(W - 1)) begin
          out_lo_d    = step_lo_s;
          out_hi_d    = step_hi_s;
          out_wr_hi_d = 1'b1;
          out_flags_d = {1'b0,
                         (!is_mul_s) && (a_q == {W{1'b0}}),
                         is_mul_s && (step_hi_s != {W{1'b0}}),
                         1'b0,
                         (step_lo_s == {W{1'b0}})};
          state_d     = S_DONE;
        end else begin
          state_d = S_ITER;
        end
      end
      S_DONE: begin
        // Result is presented one edge after DONE is entered, then held.
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
        end else if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end else begin
          out_valid_d = 1'b1;
        end
      end
      default: begin
        state_d     = S_IDLE;
        out_valid_d = 1'b0;
      end
    endcase
    in_ready_d = (state_d == S_IDLE);
    busy_d     = (state_d != S_IDLE);
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_lo    = out_lo_q;
  assign bus.out_hi    = out_hi_q;
  assign bus.out_dst1  = out_dst1_q;
  assign bus.out_dst2  = out_dst2_q;
  assign bus.out_wr_hi = out_wr_hi_q;
  assign bus.out_flags = out_flags_q;
  assign bus.busy      = busy_q;
endmodule

// File: tb/tb_alu_exec_seq.sv
// Scoreboard bench for alu_exec_seq (W=16): expected results are queued when an
// operation is offered and compared when the ALU presents its result.
module tb_alu_exec_seq;
  typedef logic [47:0] res_t; // {lo, hi, wr_hi, flags[4:0], dst1, dst2}

  logic clk;
  logic rst_n;
  int   tests_run;
  int   tests_failed;
  res_t exp_q[$];

  alu_exec_seq_if #(.W(16), .OPC_W(6), .RA_W(5)) bus ();

  alu_exec_seq #(.W(16), .OPC_W(6), .RA_W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic res_t mk(input logic [15:0] lo, input logic [15:0] hi, input logic wr,
                              input logic [4:0] fl, input logic [4:0] d1, input logic [4:0] d2);
    return {lo, hi, wr, fl, d1, d2};
  endfunction

  function automatic res_t obs();
    return {bus.out_lo, bus.out_hi, bus.out_wr_hi, bus.out_flags, bus.out_dst1, bus.out_dst2};
  endfunction

  // Reference model of the unsigned ALU semantics.
  function automatic res_t model(input logic [5:0] op, input logic [15:0] a, input logic [15:0] b,
                                 input logic [4:0] d1, input logic [4:0] d2);
    logic [15:0] lo, hi;
    logic        wr, ill, dz, v, c;
    logic [16:0] s;
    logic [31:0] p;
    int          sh;
    lo = 16'h0; hi = 16'h0; wr = 1'b0; ill = 1'b0; dz = 1'b0; v = 1'b0; c = 1'b0;
    sh = int'(a[3:0]);
    case (op)
      6'h04: begin s = {1'b0, b} + {1'b0, a}; lo = s[15:0]; c = s[16];
                   v = (a[15] == b[15]) && (lo[15] != a[15]); end
      6'h05: begin lo = b - a; c = (b >= a); v = (a[15] != b[15]) && (lo[15] != b[15]); end
      6'h06: begin lo = 16'h0 - a; c = (a == 16'h0); v = (a == 16'h8000); end
      6'h07: begin p = {16'h0, a} * {16'h0, b}; lo = p[15:0]; hi = p[31:16];
                   v = (hi != 16'h0); wr = 1'b1; end
      6'h08: begin
        wr = 1'b1;
        if (a == 16'h0) begin lo = 16'hFFFF; hi = b; dz = 1'b1; end
        else begin lo = b / a; hi = b % a; end
      end
      6'h09: lo = b | a;
      6'h0A: lo = b ^ a;
      6'h0B: lo = ~(b & a);
      6'h0C: lo = ~(b | a);
      6'h0D: lo = ~(b ^ a);
      6'h0E: lo = ~a;
      6'h0F: begin p = {16'h0, b} << sh; lo = p[15:0]; c = p[16]; end
      6'h10: begin lo = b >> sh; c = (sh == 0) ? 1'b0 : b[sh-1]; end
      default: ill = 1'b1;
    endcase
    return {lo, hi, wr, ill, dz, v, c, (!ill) && (lo == 16'h0), d1, d2};
  endfunction

  // Offer one operation and queue its expected result.
  task automatic drive_op(input logic [5:0] op, input logic [15:0] a, input logic [15:0] b,
                          input logic [4:0] d1, input logic [4:0] d2, input res_t exp);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!bus.in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    bus.in_valid  = 1'b1;
    bus.in_opcode = op;
    bus.in_a      = a;
    bus.in_b      = b;
    bus.in_dst1   = d1;
    bus.in_dst2   = d2;
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    bus.in_valid  = 1'b0;
    bus.in_opcode = 6'($urandom);
    bus.in_a      = 16'($urandom);
    bus.in_b      = 16'($urandom);
  endtask

  // Count edges after acceptance until out_valid; -1 on timeout.
  task automatic wait_out(output int lat, output bit rdy_seen);
    lat = 0;
    rdy_seen = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      lat++;
      if (bus.out_valid) break;
      if (bus.in_ready) rdy_seen = 1'b1;
      if (lat > 100) begin
        lat = -1;
        break;
      end
    end
  endtask

  // Complete the output handshake.
  task automatic xfer();
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.in_opcode = 6'h0; bus.in_a = 16'h0; bus.in_b = 16'h0;
    bus.in_dst1 = 5'h0; bus.in_dst2 = 5'h0; bus.out_ready = 1'b0;
    #12;
    tests_run++;
    if ({bus.out_valid, bus.in_ready, bus.busy, obs()} !== {1'b0, 1'b1, 1'b0, 48'h0}) begin
      tests_failed++;
      $display("FAIL reset_state got=%h exp=%h", {bus.out_valid, bus.in_ready, bus.busy, obs()},
               {1'b0, 1'b1, 1'b0, 48'h0});
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_add();
    int lat; bit rs; res_t e;
    drive_op(6'h04, 16'h0001, 16'hFFFF, 5'd3, 5'd4, mk(16'h0000, 16'h0, 1'b0, 5'b00011, 5'd3, 5'd4));
    wait_out(lat, rs);
    tests_run++;
    if (lat !== 2) begin tests_failed++; $display("FAIL add_latency got=%0d exp=2", lat); end
    e = exp_q.pop_front();
    tests_run++;
    if (obs() !== e) begin tests_failed++; $display("FAIL add_result got=%h exp=%h", obs(), e); end
    xfer();
    tests_run++;
    if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
      tests_failed++; $display("FAIL add_idle got=%b exp=01", {bus.out_valid, bus.in_ready});
    end
  endtask

  task automatic test_sub_neg();
    int lat; bit rs; res_t e;
    drive_op(6'h05, 16'h0001, 16'h8000, 5'd1, 5'd2, mk(16'h7FFF, 16'h0, 1'b0, 5'b00110, 5'd1, 5'd2));
    wait_out(lat, rs);
    e = exp_q.pop_front();
    tests_run++;
    if (obs() !== e) begin tests_failed++; $display("FAIL sub_result got=%h exp=%h", obs(), e); end
    xfer();
    drive_op(6'h06, 16'h8000, 16'h1234, 5'd7, 5'd8, mk(16'h8000, 16'h0, 1'b0, 5'b00100, 5'd7, 5'd8));
    wait_out(lat, rs);
    e = exp_q.pop_front();
    tests_run++;
    if (obs() !== e) begin tests_failed++; $display("FAIL neg_result got=%h exp=%h", obs(), e); end
    xfer();
  endtask

  task automatic test_mul();
    int lat; bit rs; res_t e;
    drive_op(6'h07, 16'h1234, 16'h5678, 5'd9, 5'd10, mk(16'h0060, 16'h0626, 1'b1, 5'b00100, 5'd9, 5'd10));
    wait_out(lat, rs);
    tests_run++;
    if (lat !== 17) begin tests_failed++; $display("FAIL mul_latency got=%0d exp=17", lat); end
    tests_run++;
    if (rs !== 1'b0) begin tests_failed++; $display("FAIL mul_in_ready got=%b exp=0", rs); end
    e = exp_q.pop_front();
    tests_run++;
    if (obs() !== e) begin tests_failed++; $display("FAIL mul_result got=%h exp=%h", obs(), e); end
    xfer();
  endtask

  task automatic test_div();
    int lat; bit rs; res_t e;
    drive_op(6'h08, 16'd7, 16'd100, 5'd11, 5'd12, mk(16'd14, 16'd2, 1'b1, 5'b00000, 5'd11, 5'd12));
    wait_out(lat, rs);
    e = exp_q.pop_front();
    tests_run++;
    if (obs() !== e) begin tests_failed++; $display("FAIL div_result got=%h exp=%h", obs(), e); end
    xfer();
    drive_op(6'h08, 16'h0000, 16'h00AB, 5'd13, 5'd14, mk(16'hFFFF, 16'h00AB, 1'b1, 5'b01000, 5'd13, 5'd14));
    wait_out(lat, rs);
    tests_run++;
    if (lat !== 17) begin tests_failed++; $display("FAIL divz_latency got=%0d exp=17", lat); end
    e = exp_q.pop_front();
    tests_run++;
    if (obs() !== e) begin tests_failed++; $display("FAIL divz_result got=%h exp=%h", obs(), e); end
    xfer();
  endtask

  task automatic test_shift_hold_ill();
    int lat; bit rs; res_t e;
    drive_op(6'h0F, 16'h0011, 16'h8001, 5'd15, 5'd16, mk(16'h0002, 16'h0, 1'b0, 5'b00010, 5'd15, 5'd16));
    wait_out(lat, rs);
    e = exp_q.pop_front();
    for (int i = 0; i < 5; i++) begin
      tests_run++;
      if ({bus.out_valid, bus.in_ready, obs()} !== {1'b1, 1'b0, e}) begin
        tests_failed++;
        $display("FAIL llsh_hold[%0d] got=%h exp=%h", i, {bus.out_valid, bus.in_ready, obs()}, {1'b1, 1'b0, e});
      end
      @(posedge clk);
      #1;
    end
    xfer();
    tests_run++;
    if ({bus.out_valid, bus.in_ready, bus.busy} !== 3'b010) begin
      tests_failed++; $display("FAIL hold_idle got=%b exp=010", {bus.out_valid, bus.in_ready, bus.busy});
    end
    drive_op(6'h3F, 16'h1111, 16'h2222, 5'd17, 5'd18, mk(16'h0, 16'h0, 1'b0, 5'b10000, 5'd17, 5'd18));
    wait_out(lat, rs);
    e = exp_q.pop_front();
    tests_run++;
    if (obs() !== e) begin tests_failed++; $display("FAIL ill_result got=%h exp=%h", obs(), e); end
    xfer();
  endtask

  task automatic test_reset_mid_mul();
    int lat; bit rs, seen; res_t e;
    drive_op(6'h07, 16'hFFFF, 16'hFFFF, 5'd19, 5'd20, mk(16'h0001, 16'hFFFE, 1'b1, 5'b00100, 5'd19, 5'd20));
    repeat (8) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    e = exp_q.pop_front(); // operation is discarded by the reset
    tests_run++;
    if ({bus.out_valid, bus.in_ready, bus.busy, obs()} !== {1'b0, 1'b1, 1'b0, 48'h0}) begin
      tests_failed++;
      $display("FAIL async_reset got=%h exp=%h", {bus.out_valid, bus.in_ready, bus.busy, obs()},
               {1'b0, 1'b1, 1'b0, 48'h0});
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.out_valid) seen = 1'b1;
    end
    tests_run++;
    if (seen !== 1'b0) begin tests_failed++; $display("FAIL reset_no_output got=%b exp=0", seen); end
    drive_op(6'h04, 16'd4, 16'd3, 5'd21, 5'd22, mk(16'd7, 16'h0, 1'b0, 5'b00000, 5'd21, 5'd22));
    wait_out(lat, rs);
    e = exp_q.pop_front();
    tests_run++;
    if (obs() !== e) begin tests_failed++; $display("FAIL post_reset_add got=%h exp=%h", obs(), e); end
    xfer();
  endtask

  task automatic test_random();
    logic [5:0] ops [15];
    int lat, exp_lat; bit rs; res_t e;
    logic [5:0] op; logic [15:0] a, b; logic [4:0] d1, d2;
    ops = '{6'h04, 6'h05, 6'h06, 6'h07, 6'h08, 6'h09, 6'h0A, 6'h0B,
            6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h10, 6'h00, 6'h2A};
    for (int i = 0; i < 30; i++) begin
      op = ops[i % 15];
      a  = 16'($urandom);
      b  = 16'($urandom);
      if (op == 6'h08 && (i % 2) == 1) a = 16'($urandom_range(1, 300));
      if (i == 12) a = 16'h0010; // shift amount 0
      d1 = 5'($urandom);
      d2 = 5'($urandom);
      drive_op(op, a, b, d1, d2, model(op, a, b, d1, d2));
      wait_out(lat, rs);
      exp_lat = (op == 6'h07 || op == 6'h08) ? 17 : 2;
      e = exp_q.pop_front();
      tests_run++;
      if (lat !== exp_lat || obs() !== e) begin
        tests_failed++;
        $display("FAIL rand[%0d] op=%h a=%h b=%h got=%h lat=%0d exp=%h lat=%0d", i, op, a, b, obs(), lat, e, exp_lat);
      end
      xfer();
    end
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    test_reset();
    test_add();
    test_sub_neg();
    test_mul();
    test_div();
    test_shift_hold_ill();
    test_reset_mid_mul();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
